// File: rtl/cmlb_pset_if.sv
// Lookup, fill and invalidate signal bundle for the set-associative code translation buffer.
interface cmlb_pset_if #(
  parameter int IP_W   = 65,
  parameter int DATA_W = 64,
  parameter int ASID_W = 21
);
  logic              lookup_en;
  logic              stall;
  logic [IP_W-1:0]   lookup_addr;
  logic              lookup_tr;
  logic [ASID_W-1:0] asid;
  logic              lookup_hit;
  logic              lookup_bypass;
  logic [DATA_W-1:0] lookup_data;
  logic              fill_en;
  logic [IP_W-1:0]   fill_addr;
  logic              fill_tr;
  logic [ASID_W-1:0] fill_asid;
  logic              fill_global;
  logic [DATA_W-1:0] fill_data;
  logic              inv_en;
  logic [1:0]        inv_mode;
  logic [IP_W-1:0]   inv_addr;
  logic              ready;

  modport master (
    output lookup_en, stall, lookup_addr, lookup_tr, asid,
    output fill_en, fill_addr, fill_tr, fill_asid, fill_global, fill_data,
    output inv_en, inv_mode, inv_addr,
    input  lookup_hit, lookup_bypass, lookup_data, ready
  );

  modport slave (
    input  lookup_en, stall, lookup_addr, lookup_tr, asid,
    input  fill_en, fill_addr, fill_tr, fill_asid, fill_global, fill_data,
    input  inv_en, inv_mode, inv_addr,
    output lookup_hit, lookup_bypass, lookup_data, ready
  );
endinterface

// File: rtl/cmlb_pset.sv
// Set-associative code translation buffer with true-LRU ranks and a sweep FSM for init/flush.
// Lookup result is registered one cycle after sampling and frozen by stall; fill/invalidate only while ready.
module cmlb_pset #(
  parameter int WAYS     = 8,
  parameter int SETS_LOG = 8,
  parameter int DATA_W   = 64,
  parameter int IP_W     = 65,
  parameter int ASID_W   = 21
) (
  input  logic        clk,
  input  logic        rst,
  cmlb_pset_if.slave  bus
);
  localparam int SETS = 1 << SETS_LOG;
  localparam int RW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [SETS_LOG-1:0] set_t;
  typedef logic [RW-1:0]       rank_t;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SWEEP} state_t;

  localparam rank_t MRU = rank_t'(WAYS - 1);

  logic              ent_valid [SETS][WAYS];
  logic              ent_tr    [SETS][WAYS];
  logic              ent_glb   [SETS][WAYS];
  logic [IP_W-1:0]   ent_tag   [SETS][WAYS];
  logic [ASID_W-1:0] ent_asid  [SETS][WAYS];
  logic [DATA_W-1:0] ent_data  [SETS][WAYS];
  rank_t             ent_rank  [SETS][WAYS];

  state_t            state;
  set_t              cnt;
  logic              sweep_ng;
  logic              ready_q;
  logic              hit_q;
  logic              byp_q;
  logic [DATA_W-1:0] data_q;

  function automatic set_t set_of(input logic [IP_W-1:0] a, input logic tr);
    return tr ? a[SETS_LOG+3:4] : a[SETS_LOG+13:14];
  endfunction

  // Mode-0 entries keep the full address but only the page bits take part in the compare.
  function automatic logic [WAYS-1:0] match_vec(input set_t s, input logic [IP_W-1:0] a,
                                                input logic tr, input logic [ASID_W-1:0] id);
    logic [WAYS-1:0] m;
    m = '0;
    for (int w = 0; w < WAYS; w++) begin
      m[w] = ent_valid[s][w] && (ent_tr[s][w] == tr)
          && (tr ? (ent_tag[s][w] == a) : (ent_tag[s][w][IP_W-1:14] == a[IP_W-1:14]))
          && ((ent_asid[s][w] == id) || ent_glb[s][w]);
    end
    return m;
  endfunction

  function automatic rank_t first_way(input logic [WAYS-1:0] m);
    rank_t r;
    r = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (m[w]) r = rank_t'(w);
    end
    return r;
  endfunction

  logic            idle;
  logic            lk_go;
  logic            lk_byp;
  logic            lk_any;
  logic            lk_upd;
  set_t            lk_set;
  logic [WAYS-1:0] lk_hit;
  rank_t           lk_way;
  rank_t           lk_rank [WAYS];
  logic            fl_do;
  logic            fl_any;
  set_t            fl_set;
  logic [WAYS-1:0] fl_hit;
  rank_t           fl_way;
  rank_t           fl_victim;
  rank_t           fl_rank [WAYS];
  logic            inv_take;
  logic            inv_one;
  logic            inv_sweep;
  set_t            iv_set;
  logic [WAYS-1:0] iv_hit;
  rank_t           iv_way;

  assign idle      = (state == ST_IDLE);
  assign inv_take  = bus.inv_en && idle && (bus.inv_mode != 2'd3);
  assign inv_one   = inv_take && (bus.inv_mode == 2'd0);
  assign inv_sweep = inv_take && (bus.inv_mode != 2'd0);
  assign fl_do     = bus.fill_en && idle && !inv_take;
  assign lk_go     = bus.lookup_en && !bus.stall;
  assign lk_byp    = (bus.lookup_addr[43:40] == 4'b1110);

  assign lk_set    = set_of(bus.lookup_addr, bus.lookup_tr);
  assign fl_set    = set_of(bus.fill_addr, bus.fill_tr);
  assign iv_set    = set_of(bus.inv_addr, bus.fill_tr);

  always_comb begin
    lk_hit    = match_vec(lk_set, bus.lookup_addr, bus.lookup_tr, bus.asid);
    fl_hit    = match_vec(fl_set, bus.fill_addr, bus.fill_tr, bus.fill_asid);
    iv_hit    = match_vec(iv_set, bus.inv_addr, bus.fill_tr, bus.asid);
    lk_any    = |lk_hit;
    fl_any    = |fl_hit;
    lk_way    = first_way(lk_hit);
    iv_way    = first_way(iv_hit);
    fl_victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ent_rank[fl_set][w] == '0) fl_victim = rank_t'(w);
    end
    fl_way = fl_any ? first_way(fl_hit) : fl_victim;
    lk_upd = lk_go && idle && !lk_byp && lk_any && !fl_do;
  end

  // Touched way goes to MRU; ways ranked above its old rank shift down to keep a permutation.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      lk_rank[w] = ent_rank[lk_set][w];
      if (rank_t'(w) == lk_way)
        lk_rank[w] = MRU;
      else if (ent_rank[lk_set][w] > ent_rank[lk_set][lk_way])
        lk_rank[w] = ent_rank[lk_set][w] - 1'b1;

      fl_rank[w] = ent_rank[fl_set][w];
      if (rank_t'(w) == fl_way)
        fl_rank[w] = MRU;
      else if (ent_rank[fl_set][w] > ent_rank[fl_set][fl_way])
        fl_rank[w] = ent_rank[fl_set][w] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      cnt      <= '0;
      sweep_ng <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        ST_INIT, ST_SWEEP: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (inv_sweep) begin
            state    <= ST_SWEEP;
            cnt      <= '0;
            sweep_ng <= (bus.inv_mode == 2'd2);
            ready_q  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_INIT;
          cnt     <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        for (int w = 0; w < WAYS; w++) begin
          ent_valid[cnt][w] <= 1'b0;
          ent_rank[cnt][w]  <= rank_t'(w);
        end
      end else if (state == ST_SWEEP) begin
        for (int w = 0; w < WAYS; w++) begin
          if (!sweep_ng || !ent_glb[cnt][w]) ent_valid[cnt][w] <= 1'b0;
        end
      end else begin
        // A fill owns the write port, so a concurrent lookup loses its LRU update.
        if (fl_do) begin
          ent_valid[fl_set][fl_way] <= 1'b1;
          ent_tr[fl_set][fl_way]    <= bus.fill_tr;
          ent_glb[fl_set][fl_way]   <= bus.fill_global;
          ent_tag[fl_set][fl_way]   <= bus.fill_addr;
          ent_asid[fl_set][fl_way]  <= bus.fill_asid;
          ent_data[fl_set][fl_way]  <= bus.fill_data;
          for (int w = 0; w < WAYS; w++) ent_rank[fl_set][w] <= fl_rank[w];
        end else if (lk_upd) begin
          for (int w = 0; w < WAYS; w++) ent_rank[lk_set][w] <= lk_rank[w];
        end
        if (inv_one && (|iv_hit)) ent_valid[iv_set][iv_way] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= 1'b0;
      byp_q  <= 1'b0;
      data_q <= '0;
    end else if (lk_go) begin
      if (!idle) begin
        hit_q  <= 1'b0;
        byp_q  <= 1'b0;
        data_q <= '0;
      end else if (lk_byp) begin
        hit_q  <= 1'b1;
        byp_q  <= 1'b1;
        data_q <= '0;
      end else begin
        hit_q  <= lk_any;
        byp_q  <= 1'b0;
        data_q <= lk_any ? ent_data[lk_set][lk_way] : '0;
      end
    end
  end

  // Duplicate hits mean the fill path installed the same translation twice.
  always_ff @(posedge clk) begin
    if (!rst && idle && lk_go && !lk_byp) assert ($onehot0(lk_hit));
    if (!rst && fl_do) assert ($onehot0(fl_hit));
  end

  assign bus.lookup_hit    = hit_q;
  assign bus.lookup_bypass = byp_q;
  assign bus.lookup_data   = data_q;
  assign bus.ready         = ready_q;
endmodule

// File: tb/tb_cmlb_pset.sv
// Randomised and directed bench for cmlb_pset against a timestamp-LRU reference model.
module tb_cmlb_pset;
  localparam int SETS = 256;
  localparam int WAYS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmlb_pset_if bus ();
  cmlb_pset dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: one record per way, LRU victim = oldest last-touch time.
  bit          mv [SETS][WAYS];
  bit          mm [SETS][WAYS];
  bit          mg [SETS][WAYS];
  logic [64:0] mt [SETS][WAYS];
  logic [20:0] ma [SETS][WAYS];
  logic [63:0] md [SETS][WAYS];
  longint      ts [SETS][WAYS];
  longint      now;
  int          busy;
  logic        eh, eb;
  logic [63:0] ed;

  function automatic int set_of(input logic [64:0] a, input bit tr);
    return tr ? int'(a[11:4]) : int'(a[21:14]);
  endfunction

  function automatic int find(input logic [64:0] a, input bit tr, input logic [20:0] id);
    int s = set_of(a, tr);
    int r = -1;
    for (int w = 0; w < WAYS; w++) begin
      if (r < 0 && mv[s][w] && mm[s][w] == tr
          && (tr ? (mt[s][w] == a) : (mt[s][w][64:14] == a[64:14]))
          && (ma[s][w] == id || mg[s][w]))
        r = w;
    end
    return r;
  endfunction

  task automatic model_step();
    int s, w;
    bit take, fdo;
    if (rst) begin
      for (int i = 0; i < SETS; i++)
        for (int k = 0; k < WAYS; k++) begin
          mv[i][k] = 0;
          ts[i][k] = k;
        end
      now = WAYS - 1;
      busy = SETS;
      eh = 0; eb = 0; ed = 0;
      return;
    end
    if (busy > 0) begin
      busy--;
      if (bus.lookup_en && !bus.stall) begin eh = 0; eb = 0; ed = 0; end
      return;
    end
    take = bus.inv_en && bus.inv_mode != 2'd3;
    fdo  = bus.fill_en && !take;
    if (bus.lookup_en && !bus.stall) begin
      if (bus.lookup_addr[43:40] == 4'hE) begin
        eh = 1; eb = 1; ed = 0;
      end else begin
        s = set_of(bus.lookup_addr, bus.lookup_tr);
        w = find(bus.lookup_addr, bus.lookup_tr, bus.asid);
        eh = (w >= 0); eb = 0; ed = 0;
        if (w >= 0) begin
          ed = md[s][w];
          if (!fdo) begin now++; ts[s][w] = now; end
        end
      end
    end
    if (take && bus.inv_mode == 2'd0) begin
      s = set_of(bus.inv_addr, bus.fill_tr);
      w = find(bus.inv_addr, bus.fill_tr, bus.asid);
      if (w >= 0) mv[s][w] = 0;
    end else if (take) begin
      for (int i = 0; i < SETS; i++)
        for (int k = 0; k < WAYS; k++)
          if (bus.inv_mode == 2'd1 || !mg[i][k]) mv[i][k] = 0;
      busy = SETS;
    end
    if (fdo) begin
      s = set_of(bus.fill_addr, bus.fill_tr);
      w = find(bus.fill_addr, bus.fill_tr, bus.fill_asid);
      if (w < 0) begin
        w = 0;
        for (int k = 1; k < WAYS; k++) if (ts[s][k] < ts[s][w]) w = k;
      end
      mv[s][w] = 1; mm[s][w] = bus.fill_tr; mg[s][w] = bus.fill_global;
      mt[s][w] = bus.fill_addr; ma[s][w] = bus.fill_asid; md[s][w] = bus.fill_data;
      now++; ts[s][w] = now;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("ready", 64'(bus.ready), 64'(busy == 0 && !rst));
    chk("hit", 64'(bus.lookup_hit), 64'(eh));
    chk("bypass", 64'(bus.lookup_bypass), 64'(eb));
    chk("data", bus.lookup_data, ed);
  endtask

  task automatic clear_in();
    bus.lookup_en = 0; bus.stall = 0; bus.lookup_addr = '0; bus.lookup_tr = 0; bus.asid = '0;
    bus.fill_en = 0; bus.fill_addr = '0; bus.fill_tr = 0; bus.fill_asid = '0;
    bus.fill_global = 0; bus.fill_data = '0;
    bus.inv_en = 0; bus.inv_mode = '0; bus.inv_addr = '0;
  endtask

  task automatic fill_op(input bit tr, input logic [64:0] a, input logic [20:0] id,
                         input bit glb, input logic [63:0] d);
    bus.fill_en = 1; bus.fill_tr = tr; bus.fill_addr = a; bus.fill_asid = id;
    bus.fill_global = glb; bus.fill_data = d;
    step();
    bus.fill_en = 0;
  endtask

  task automatic look(input bit tr, input logic [64:0] a, input logic [20:0] id);
    bus.lookup_en = 1; bus.lookup_tr = tr; bus.lookup_addr = a; bus.asid = id;
    step();
    bus.lookup_en = 0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.ready && n < 2000) begin step(); n++; end
    chk(tag, 64'(n), 64'd256);
  endtask

  task automatic inv_op(input logic [1:0] mode);
    bus.inv_en = 1; bus.inv_mode = mode;
    step();
    bus.inv_en = 0;
  endtask

  function automatic logic [64:0] rnd_addr(input bit tr);
    logic [64:0] a = '0;
    a[24:22] = 3'($urandom_range(0, 3));
    if (tr) begin
      a[11:4] = 8'($urandom_range(0, 3));
      a[3:0]  = 4'($urandom_range(0, 1));
    end else begin
      a[21:14] = 8'($urandom_range(0, 3));
      a[13:0]  = 14'($urandom);
    end
    return a;
  endfunction

  logic [64:0] pg, a1;

  initial begin
    clear_in();
    bus.lookup_en = 1;
    bus.lookup_addr = 65'h0000_1234_5123;
    rst = 1;
    step(); step();
    rst = 0;
    wait_ready("init_len");
    bus.lookup_en = 0;

    pg = 65'h0000_1234_5000;
    fill_op(0, pg, 21'd5, 0, 64'hAA);
    look(0, pg + 65'h123, 21'd5);
    chk("asid5_hit", 64'(bus.lookup_hit), 64'd1);
    chk("asid5_data", bus.lookup_data, 64'hAA);
    look(0, pg + 65'h123, 21'd6);
    chk("asid6_miss", 64'(bus.lookup_hit), 64'd0);
    fill_op(0, pg, 21'd5, 1, 64'hAA);
    look(0, pg + 65'h123, 21'd6);
    chk("global_hit", 64'(bus.lookup_hit), 64'd1);

    for (int i = 1; i <= 8; i++)
      fill_op(0, (65'(i) << 22) | (65'h40 << 14), 21'd3, 0, 64'h100 + 64'(i));
    look(0, (65'd1 << 22) | (65'h40 << 14), 21'd3);
    fill_op(0, (65'd9 << 22) | (65'h40 << 14), 21'd3, 0, 64'h109);
    look(0, (65'd2 << 22) | (65'h40 << 14), 21'd3);
    chk("evict_2nd", 64'(bus.lookup_hit), 64'd0);
    look(0, (65'd1 << 22) | (65'h40 << 14), 21'd3);
    chk("keep_1st", bus.lookup_data, 64'h101);
    look(0, (65'd9 << 22) | (65'h40 << 14), 21'd3);
    chk("new_9th", bus.lookup_data, 64'h109);

    for (int i = 1; i <= 4; i++)
      fill_op(0, (65'(i) << 22) | (65'h50 << 14), 21'd7, i <= 2, 64'h200 + 64'(i));
    inv_op(2'd2);
    bus.lookup_en = 1;
    wait_ready("sweep_ng_len");
    bus.lookup_en = 0;
    for (int i = 1; i <= 4; i++) begin
      look(0, (65'(i) << 22) | (65'h50 << 14), 21'd7);
      chk("ng_flush", 64'(bus.lookup_hit), 64'(i <= 2));
    end
    inv_op(2'd1);
    wait_ready("sweep_all_len");
    for (int i = 1; i <= 2; i++) begin
      look(0, (65'(i) << 22) | (65'h50 << 14), 21'd7);
      chk("all_flush", 64'(bus.lookup_hit), 64'd0);
    end

    look(0, 65'h0E00_0000_0123, 21'd1);
    chk("byp_hit", 64'(bus.lookup_hit), 64'd1);
    chk("byp_flag", 64'(bus.lookup_bypass), 64'd1);
    chk("byp_data", bus.lookup_data, 64'd0);
    bus.stall = 1; bus.lookup_en = 1; bus.lookup_addr = pg;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", 64'(bus.lookup_bypass), 64'd1);
    end
    clear_in();

    a1 = 65'h0000_2000_0000;
    fill_op(0, a1, 21'd4, 0, 64'h55);
    bus.asid = 21'd4; bus.inv_en = 1; bus.inv_mode = 2'd0; bus.inv_addr = a1;
    fill_op(0, a1, 21'd4, 0, 64'h66);
    bus.inv_en = 0;
    look(0, a1, 21'd4);
    chk("fill_inv_clash", 64'(bus.lookup_hit), 64'd0);

    inv_op(2'd1);
    for (int i = 0; i < 40; i++) step();
    rst = 1; step(); rst = 0;
    wait_ready("rst_in_sweep");

    for (int c = 0; c < 1500; c++) begin
      bus.lookup_en = $urandom_range(0, 3) != 0;
      bus.stall = $urandom_range(0, 7) == 0;
      bus.lookup_tr = 1'($urandom_range(0, 1));
      bus.lookup_addr = ($urandom_range(0, 15) == 0) ? 65'h0E00_0000_0040 : rnd_addr(bus.lookup_tr);
      bus.asid = 21'($urandom_range(1, 2));
      bus.fill_en = $urandom_range(0, 3) == 0;
      bus.fill_tr = 1'($urandom_range(0, 1));
      bus.fill_addr = rnd_addr(bus.fill_tr);
      bus.fill_asid = 21'($urandom_range(1, 2));
      bus.fill_global = bus.fill_addr[22];
      bus.fill_data = {32'($urandom), 32'($urandom)};
      bus.inv_en = $urandom_range(0, 15) == 0;
      bus.inv_mode = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 2))
                                                 : (($urandom_range(0, 3) == 0) ? 2'd3 : 2'd0);
      bus.inv_addr = rnd_addr(bus.fill_tr);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
